// File: rtl/led_scan_capture_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan capture block.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package led_scan_capture_pkg;

  localparam int unsigned NumDigits = 8;

  // Index n holds the glyph for hex digit n.
  localparam logic [15:0][6:0] Glyph = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } scan_state_e;

  function automatic logic is_onehot_low(input logic [7:0] sel);
    return $onehot(~sel);
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment glyph to hex nibble decoder.
// Unknown glyphs decode to nibble 0 with err_o set.
module seg7_to_hex
  import led_scan_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b1;
    for (int unsigned g = 0; g < 16; g++) begin
      if (seg_i == Glyph[g]) begin
        nibble_o = 4'(g);
        err_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_scan_capture.sv
// Captures a multiplexed 8-digit 7-segment scan into a 32-bit hex word once every
// digit has been seen stable; also flags bad selects and a stalled scan.
module led_scan_capture
  import led_scan_capture_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  LEDSEL,
  input  logic [7:0]  LEDOUT,
  output logic [31:0] hex_word,
  output logic [7:0]  dp_word,
  output logic [7:0]  digit_err,
  output logic        frame_valid,
  output logic        sel_err,
  output logic        stale
);

  localparam logic [7:0]  StableMax  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TimeoutMax = 16'(TIMEOUT_CYCLES);

  logic [15:0] sample_in;
  logic [15:0] samp_q, samp_d;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] tmo_q, tmo_d;
  scan_state_e state_q, state_d;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] sh_hex_q, sh_hex_d;
  logic [7:0]  sh_dp_q, sh_dp_d;
  logic [7:0]  sh_err_q, sh_err_d;
  logic [31:0] hex_q, hex_d;
  logic [7:0]  dp_q, dp_d;
  logic [7:0]  derr_q, derr_d;
  logic        fv_q, fv_d;
  logic        sel_err_q, sel_err_d;

  logic        changed, in_ff, capture, accept, frame_fire;
  logic [3:0]  dec_nibble;
  logic        dec_err;

  assign sample_in = {LEDSEL, LEDOUT};
  assign changed   = (sample_in != samp_q);
  assign in_ff     = (LEDSEL == 8'hFF);

  seg7_to_hex u_dec (
    .seg_i    (~samp_q[6:0]),
    .nibble_o (dec_nibble),
    .err_o    (dec_err)
  );

  always_comb begin
    samp_d  = sample_in;
    stab_d  = changed ? 8'd0 : ((stab_q == StableMax) ? stab_q : stab_q + 8'd1);
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (changed && !in_ff) state_d = StSettle;
      end
      StSettle: begin
        if (changed) begin
          state_d = in_ff ? StIdle : StSettle;
        end else if (stab_d == StableMax) begin
          state_d = StHold;
          capture = 1'b1;
        end
      end
      StHold: begin
        if (changed) state_d = in_ff ? StIdle : StSettle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full seen mask publishes the shadow one clock after the completing capture.
  assign frame_fire = (seen_q == 8'hFF);

  always_comb begin
    seen_d    = frame_fire ? 8'h00 : seen_q;
    sh_hex_d  = sh_hex_q;
    sh_dp_d   = sh_dp_q;
    sh_err_d  = sh_err_q;
    sel_err_d = sel_err_q;
    accept    = 1'b0;
    if (capture) begin
      if (is_onehot_low(samp_q[15:8])) begin
        accept = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (!samp_q[8+i]) begin
            sh_hex_d[4*i +: 4] = dec_nibble;
            sh_dp_d[i]         = ~samp_q[7];
            sh_err_d[i]        = dec_err;
            seen_d[i]          = 1'b1;
          end
        end
      end else begin
        sel_err_d = 1'b1;
      end
    end
    hex_d  = frame_fire ? sh_hex_q : hex_q;
    dp_d   = frame_fire ? sh_dp_q : dp_q;
    derr_d = frame_fire ? sh_err_q : derr_q;
    fv_d   = frame_fire;
    tmo_d  = accept ? 16'd0 : ((tmo_q == TimeoutMax) ? tmo_q : tmo_q + 16'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q    <= 16'hFFFF;
      stab_q    <= 8'd0;
      tmo_q     <= 16'd0;
      state_q   <= StIdle;
      seen_q    <= 8'h00;
      sh_hex_q  <= 32'h0;
      sh_dp_q   <= 8'h00;
      sh_err_q  <= 8'h00;
      hex_q     <= 32'h0;
      dp_q      <= 8'h00;
      derr_q    <= 8'h00;
      fv_q      <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      state_q   <= state_d;
      seen_q    <= seen_d;
      sh_hex_q  <= sh_hex_d;
      sh_dp_q   <= sh_dp_d;
      sh_err_q  <= sh_err_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      derr_q    <= derr_d;
      fv_q      <= fv_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign hex_word    = hex_q;
  assign dp_word     = dp_q;
  assign digit_err   = derr_q;
  assign frame_valid = fv_q;
  assign sel_err     = sel_err_q;
  assign stale       = (tmo_q == TimeoutMax);

endmodule

// File: tb/tb_led_scan_capture.sv
// Self-checking bench: directed scans plus random scan traffic against a
// run-length based reference model of the capture rules.
module tb_led_scan_capture;

  localparam int unsigned Stable  = 4;
  localparam int unsigned Timeout = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  LEDSEL;
  logic [7:0]  LEDOUT;
  logic [31:0] hex_word;
  logic [7:0]  dp_word;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        sel_err;
  logic        stale;

  always #5 clk = ~clk;

  led_scan_capture #(
    .STABLE_CYCLES  (Stable),
    .TIMEOUT_CYCLES (Timeout)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .LEDSEL      (LEDSEL),
    .LEDOUT      (LEDOUT),
    .hex_word    (hex_word),
    .dp_word     (dp_word),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .sel_err     (sel_err),
    .stale       (stale)
  );

  int checks = 0;
  int errors = 0;
  int fv_count = 0;

  // Reference model state: run length of the current input and frame bookkeeping.
  logic [15:0] m_last;
  int          m_run;
  logic [7:0]  m_seen;
  logic [31:0] m_sh_hex;
  logic [7:0]  m_sh_dp, m_sh_err;
  logic [31:0] m_hex;
  logic [7:0]  m_dp, m_derr;
  logic        m_fv, m_pend, m_selerr;
  int          m_since;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic int glyph_val(input logic [6:0] s);
    for (int v = 0; v < 16; v++) if (glyph_of(v) == s) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 16'hFFFF; m_run = 0; m_seen = 8'h00;
    m_sh_hex = 32'h0; m_sh_dp = 8'h00; m_sh_err = 8'h00;
    m_hex = 32'h0; m_dp = 8'h00; m_derr = 8'h00;
    m_fv = 1'b0; m_pend = 1'b0; m_selerr = 1'b0; m_since = 0;
  endtask

  // One rising edge: a value is captured when it has been presented on exactly
  // Stable+1 consecutive edges and the select is not blank.
  task automatic model_edge(input logic [7:0] sel, input logic [7:0] seg);
    int  v, idx;
    logic ok;
    ok   = 1'b0;
    m_fv = 1'b0;
    if (m_pend) begin
      m_hex = m_sh_hex; m_dp = m_sh_dp; m_derr = m_sh_err;
      m_fv = 1'b1; m_seen = 8'h00; m_pend = 1'b0;
    end
    if ({sel, seg} == m_last) m_run++;
    else m_run = 1;
    m_last = {sel, seg};
    if (m_run == Stable + 1 && sel != 8'hFF) begin
      if ($countones(~sel) == 1) begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (!sel[i]) idx = i;
        v = glyph_val(~seg[6:0]);
        m_sh_hex[4*idx +: 4] = (v < 0) ? 4'h0 : v[3:0];
        m_sh_dp[idx]  = ~seg[7];
        m_sh_err[idx] = (v < 0);
        m_seen[idx]   = 1'b1;
        if (m_seen == 8'hFF) m_pend = 1'b1;
        ok = 1'b1;
      end else begin
        m_selerr = 1'b1;
      end
    end
    m_since = ok ? 0 : m_since + 1;
  endtask

  task automatic tick(input logic [7:0] sel, input logic [7:0] seg);
    LEDSEL = sel;
    LEDOUT = seg;
    @(posedge clk);
    model_edge(sel, seg);
    @(negedge clk);
    if (frame_valid === 1'b1) fv_count++;
    check_eq("frame_valid", frame_valid, m_fv);
    check_eq("hex_word", hex_word, m_hex);
    check_eq("dp_word", dp_word, m_dp);
    check_eq("digit_err", digit_err, m_derr);
    check_eq("sel_err", sel_err, m_selerr);
    check_eq("stale", stale, (m_since >= Timeout));
  endtask

  task automatic scan_digit(input int d, input logic [6:0] glyph, input logic dp, input int cyc);
    logic [7:0] sel;
    sel = ~(8'd1 << d);
    repeat (cyc) tick(sel, {~dp, ~glyph});
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) tick(8'hFF, 8'hFF);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    LEDSEL = 8'hFF;
    LEDOUT = 8'hFF;
    model_reset();
    @(negedge clk);
    check_eq("rst_hex", hex_word, 32'h0);
    check_eq("rst_dp", dp_word, 8'h00);
    check_eq("rst_derr", digit_err, 8'h00);
    check_eq("rst_fv", frame_valid, 1'b0);
    check_eq("rst_selerr", sel_err, 1'b0);
    check_eq("rst_stale", stale, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    LEDSEL = 8'hFF;
    LEDOUT = 8'hFF;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Stale rises on the 20th clock with no scan.
    idle(19);
    check_eq("stale_clk19", stale, 1'b0);
    idle(1);
    check_eq("stale_clk20", stale, 1'b1);
    idle(3);

    // A capture landing on clock 20 keeps stale low.
    apply_reset();
    idle(15);
    scan_digit(0, glyph_of(5), 1'b0, 5);
    check_eq("cap_on_clk20_stale", stale, 1'b0);
    scan_digit(0, glyph_of(5), 1'b0, 5);

    // Basic frame: digit i shows glyph i+1.
    apply_reset();
    fv_count = 0;
    for (int d = 0; d < 8; d++) scan_digit(d, glyph_of(d + 1), 1'b0, 10);
    check_eq("frame_count", fv_count, 1);
    check_eq("frame_hex", hex_word, 32'h87654321);
    check_eq("frame_derr", digit_err, 8'h00);
    check_eq("frame_dp", dp_word, 8'h00);

    // Three cycles on digit 0 is too short, so digits 1..7 alone complete nothing.
    fv_count = 0;
    scan_digit(0, glyph_of(9), 1'b1, 3);
    for (int d = 1; d < 8; d++) scan_digit(d, glyph_of(d + 8), 1'b0, 10);
    check_eq("short_hold_no_frame", fv_count, 0);
    scan_digit(0, glyph_of(9), 1'b1, 10);
    check_eq("short_hold_then_frame", fv_count, 1);
    check_eq("short_hold_hex", hex_word, 32'hFEDCBA99);
    check_eq("short_hold_dp", dp_word, 8'h01);

    // Illegal select sets sticky sel_err.
    repeat (10) tick(8'hFC, 8'h80);
    check_eq("sel_err_set", sel_err, 1'b1);
    idle(10);
    check_eq("sel_err_sticky", sel_err, 1'b1);

    // 8 with segment a off is not a hex glyph.
    fv_count = 0;
    for (int d = 0; d < 8; d++) scan_digit(d, (d == 2) ? 7'h7E : glyph_of(d), 1'b0, 10);
    check_eq("bad_glyph_frame", fv_count, 1);
    check_eq("bad_glyph_derr", digit_err, 8'h04);
    check_eq("bad_glyph_hex", hex_word, 32'h76543010);

    // Reset mid-frame discards the partial frame.
    for (int d = 0; d < 5; d++) scan_digit(d, glyph_of(d + 3), 1'b0, 10);
    apply_reset();
    fv_count = 0;
    for (int d = 0; d < 8; d++) begin
      scan_digit(d, glyph_of(15 - d), 1'b0, 10);
      if (d == 6) check_eq("mid_reset_no_early_frame", fv_count, 0);
    end
    check_eq("mid_reset_one_frame", fv_count, 1);
    check_eq("mid_reset_hex", hex_word, 32'h89ABCDEF);

    // Random scan traffic.
    for (int n = 0; n < 400; n++) begin
      int         kind, cyc;
      logic [7:0] sel;
      logic [6:0] gl;
      kind = int'($urandom_range(0, 11));
      cyc  = int'($urandom_range(1, 9));
      if (kind == 10) sel = 8'hFF;
      else if (kind == 11) sel = 8'($urandom);
      else sel = ~(8'd1 << (kind % 8));
      if ($urandom_range(0, 7) == 0) gl = 7'($urandom);
      else gl = glyph_of(int'($urandom_range(0, 15)));
      repeat (cyc) tick(sel, {1'($urandom), ~gl});
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
